// File: rtl/execute_stage_md.sv
// execute_stage_md: RISC-V execute stage with operand forwarding, ALU and branch resolution.
// Define EXEC_MULDIV_EN to build the iterative multiply/divide unit and its stall FSM.
module execute_stage_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mispredict_flush,
    input  logic            instruction_valid,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] opa_mux_in,
    input  logic [XLEN-1:0] opb_mux_in,
    input  logic [XLEN-1:0] pc_address,
    input  logic [XLEN-1:0] imm,
    input  logic            is_branch,
    input  logic [2:0]      branch_funct3,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_data,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_out_address,
    output logic            result_valid,
    output logic [XLEN-1:0] branch_target,
    output logic            branch_taken,
    output logic            stall
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0] opa_s, opb_s, alu_s, target_s, md_result_s;
    logic [SHW-1:0]  shamt_s;
    logic            cond_s, taken_s, md_done_s;

    // Explicit forwarding select for operand A
    always_comb begin
        case (forward_a)
            2'b00:   opa_s = opa_mux_in;
            2'b01:   opa_s = ex_data;
            2'b10:   opa_s = mem_data;
            2'b11:   opa_s = wb_data;
            default: opa_s = opa_mux_in;
        endcase
    end

    // Explicit forwarding select for operand B
    always_comb begin
        case (forward_b)
            2'b00:   opb_s = opb_mux_in;
            2'b01:   opb_s = ex_data;
            2'b10:   opb_s = mem_data;
            2'b11:   opb_s = wb_data;
            default: opb_s = opb_mux_in;
        endcase
    end

    assign shamt_s = opb_s[SHW-1:0];

    // Single-cycle integer ALU; unlisted codes (including M codes when not built) add
    always_comb begin
        case (alu_control)
            5'b00000: alu_s = opa_s + opb_s;
            5'b01000: alu_s = opa_s - opb_s;
            5'b00001: alu_s = opa_s << shamt_s;
            5'b00101: alu_s = opa_s >> shamt_s;
            5'b01101: alu_s = $unsigned($signed(opa_s) >>> shamt_s);
            5'b00010: alu_s = {{(XLEN-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
            5'b00011: alu_s = {{(XLEN-1){1'b0}}, (opa_s < opb_s)};
            5'b00100: alu_s = opa_s ^ opb_s;
            5'b00110: alu_s = opa_s | opb_s;
            5'b00111: alu_s = opa_s & opb_s;
            default:  alu_s = opa_s + opb_s;
        endcase
    end

    // Conditional branch evaluation on the forwarded operands
    always_comb begin
        case (branch_funct3)
            3'b000:  cond_s = (opa_s == opb_s);
            3'b001:  cond_s = (opa_s != opb_s);
            3'b100:  cond_s = ($signed(opa_s) < $signed(opb_s));
            3'b101:  cond_s = ($signed(opa_s) >= $signed(opb_s));
            3'b110:  cond_s = (opa_s < opb_s);
            3'b111:  cond_s = (opa_s >= opb_s);
            default: cond_s = 1'b0;
        endcase
    end

    assign taken_s  = is_branch & cond_s;
    assign target_s = pc_address + imm;

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} md_state_t;
    localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);
    localparam logic [SHW-1:0] ONE_STEP  = SHW'(1);

    md_state_t         state_r;
    logic [SHW-1:0]    count_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2:0]        op_r;
    logic              neg_q_r, neg_r_r, divzero_r;
    logic              mop_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] prod_fix_s;

    assign mop_s = (alu_control[4:3] == 2'b10);

    // Signedness of each operand for the presented M op
    always_comb begin
        if (alu_control[2]) begin
            a_sgn_s = ~alu_control[0];
            b_sgn_s = ~alu_control[0];
        end else begin
            a_sgn_s = (alu_control[1:0] != 2'b11);
            b_sgn_s = ~alu_control[1];
        end
    end

    assign a_neg_s = a_sgn_s & opa_s[XLEN-1];
    assign b_neg_s = b_sgn_s & opb_s[XLEN-1];
    assign a_mag_s = a_neg_s ? (-opa_s) : opa_s;
    assign b_mag_s = b_neg_s ? (-opb_s) : opb_s;

    // acc_r holds {high, low} for multiply and {remainder, quotient} for divide
    assign mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
    assign div_shift_s = acc_r[2*XLEN-1:XLEN-1];
    assign div_diff_s  = div_shift_s - {1'b0, mcand_r};

    assign prod_fix_s = neg_q_r ? (-acc_r) : acc_r;
    assign quo_fix_s  = divzero_r ? {XLEN{1'b1}} : (neg_q_r ? (-acc_r[XLEN-1:0]) : acc_r[XLEN-1:0]);
    assign rem_fix_s  = neg_r_r ? (-acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];

    // Final sign-corrected M result selection
    always_comb begin
        if (op_r[2]) begin
            md_result_s = op_r[1] ? rem_fix_s : quo_fix_s;
        end else if (op_r[1:0] == 2'b00) begin
            md_result_s = prod_fix_s[XLEN-1:0];
        end else begin
            md_result_s = prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    assign md_done_s = (state_r == DONE);
    assign stall     = rst & ~mispredict_flush &
                       (((state_r == IDLE) & instruction_valid & mop_s) | (state_r == BUSY));

    // Iterative multiply/divide FSM: latch, XLEN fixed steps, then one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            count_r   <= {SHW{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            mcand_r   <= ZERO;
            op_r      <= 3'b000;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            divzero_r <= 1'b0;
        end else if (mispredict_flush) begin
            state_r <= IDLE;
            count_r <= {SHW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (instruction_valid && mop_s) begin
                        state_r   <= BUSY;
                        count_r   <= {SHW{1'b0}};
                        op_r      <= alu_control[2:0];
                        mcand_r   <= alu_control[2] ? b_mag_s : a_mag_s;
                        acc_r     <= {ZERO, (alu_control[2] ? a_mag_s : b_mag_s)};
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_r_r   <= a_neg_s;
                        divzero_r <= (opb_s == ZERO);
                    end
                end
                BUSY: begin
                    if (op_r[2]) begin
                        acc_r <= {(div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0]),
                                  acc_r[XLEN-2:0], ~div_diff_s[XLEN]};
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[XLEN-1:1]};
                    end
                    count_r <= count_r + ONE_STEP;
                    if (count_r == LAST_STEP) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end
`else
    assign stall       = 1'b0;
    assign md_done_s   = 1'b0;
    assign md_result_s = ZERO;
`endif

    // Registered outputs: flush/invalid and stall bubbles clear, otherwise load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_address <= ZERO;
            result_valid    <= 1'b0;
            branch_target   <= ZERO;
            branch_taken    <= 1'b0;
        end else if (mispredict_flush || !instruction_valid) begin
            alu_out_address <= ZERO;
            result_valid    <= 1'b0;
            branch_target   <= ZERO;
            branch_taken    <= 1'b0;
        end else if (md_done_s) begin
            alu_out_address <= md_result_s;
            result_valid    <= 1'b1;
            branch_target   <= target_s;
            branch_taken    <= taken_s;
        end else if (stall) begin
            alu_out_address <= ZERO;
            result_valid    <= 1'b0;
            branch_target   <= ZERO;
            branch_taken    <= 1'b0;
        end else begin
            alu_out_address <= alu_s;
            result_valid    <= 1'b1;
            branch_target   <= target_s;
            branch_taken    <= taken_s;
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed self-checking bench for execute_stage_md (XLEN=32); M-unit steps run when EXEC_MULDIV_EN is defined.
module tb_execute_stage_md;
    logic        clk, rst, mispredict_flush, instruction_valid, is_branch;
    logic [4:0]  alu_control;
    logic [31:0] opa_mux_in, opb_mux_in, pc_address, imm, ex_data, mem_data, wb_data;
    logic [2:0]  branch_funct3;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] alu_out_address, branch_target;
    logic        result_valid, branch_taken, stall;

    int checks   = 0;
    int failures = 0;

    execute_stage_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .mispredict_flush(mispredict_flush),
        .instruction_valid(instruction_valid), .alu_control(alu_control),
        .opa_mux_in(opa_mux_in), .opb_mux_in(opb_mux_in), .pc_address(pc_address),
        .imm(imm), .is_branch(is_branch), .branch_funct3(branch_funct3),
        .forward_a(forward_a), .forward_b(forward_b), .ex_data(ex_data),
        .mem_data(mem_data), .wb_data(wb_data), .alu_out_address(alu_out_address),
        .result_valid(result_valid), .branch_target(branch_target),
        .branch_taken(branch_taken), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_control       = c;
        opa_mux_in        = a;
        opb_mux_in        = b;
        instruction_valid = 1'b1;
        forward_a         = 2'b00;
        forward_b         = 2'b00;
        is_branch         = 1'b0;
        branch_funct3     = 3'b010;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        set_op(c, a, b);
        tick();
        chk(tag, alu_out_address, exp);
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic br,
                          input logic [31:0] a, input logic [31:0] b, input logic exp);
        set_op(5'b00000, a, b);
        is_branch     = br;
        branch_funct3 = f3;
        tick();
        chk(tag, {31'd0, branch_taken}, {31'd0, exp});
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_mop(input string tag, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int   n;
        logic early;
        set_op(c, a, b);
        #1;
        n     = 0;
        early = 1'b0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            if (result_valid !== 1'b0) early = 1'b1;
            tick();
        end
        if (result_valid !== 1'b0) early = 1'b1;
        chk({tag, "_stall_cycles"}, n, 32'd33);
        chk({tag, "_valid_early"}, {31'd0, early}, 32'd0);
        tick();
        chk({tag, "_result"}, alu_out_address, exp);
        chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        instruction_valid = 1'b0;
        tick();
        chk({tag, "_valid_pulse"}, {31'd0, result_valid}, 32'd0);
    endtask
`endif

    initial begin
        rst = 1'b0; mispredict_flush = 1'b0; ex_data = 32'd0; mem_data = 32'd0; wb_data = 32'd0;
        pc_address = 32'h0000_1000; imm = 32'h0000_0010;
        set_op(5'b10100, 32'd7, 32'd3);
        tick();
        tick();
        // Reset held with a valid M op presented
        chk("rst_out", alu_out_address, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_target", branch_target, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        instruction_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Forwarding from WB, then from MEM/EX
        set_op(5'b00000, 32'h63, 32'd3);
        forward_a = 2'b11; wb_data = 32'd7; ex_data = 32'd100; mem_data = 32'd200;
        pc_address = 32'h0000_1000; imm = 32'h0000_0010;
        tick();
        chk("fwd_wb_result", alu_out_address, 32'h0000_000A);
        chk("fwd_wb_target", branch_target, 32'h0000_1010);
        chk("fwd_wb_taken", {31'd0, branch_taken}, 32'd0);
        chk("fwd_wb_valid", {31'd0, result_valid}, 32'd1);
        set_op(5'b01000, 32'h63, 32'd3);
        forward_a = 2'b10; forward_b = 2'b01;
        tick();
        chk("fwd_mem_ex_sub", alu_out_address, 32'd100);

        // Signed vs unsigned branch and compare
        imm = 32'h0000_0040;
        run_br("blt", 3'b100, 1'b1, 32'hFFFF_FFFE, 32'd1, 1'b1);
        chk("blt_target", branch_target, 32'h0000_1040);
        chk("blt_add", alu_out_address, 32'hFFFF_FFFF);
        run_br("bltu", 3'b110, 1'b1, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_br("bge", 3'b101, 1'b1, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_br("bgeu", 3'b111, 1'b1, 32'hFFFF_FFFE, 32'd1, 1'b1);
        run_br("beq", 3'b000, 1'b1, 32'd5, 32'd5, 1'b1);
        run_br("bne", 3'b001, 1'b1, 32'd5, 32'd5, 1'b0);
        run_br("f3_010", 3'b010, 1'b1, 32'd5, 32'd5, 1'b0);
        run_br("not_branch", 3'b100, 1'b0, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_alu("slt", 5'b00010, 32'hFFFF_FFFE, 32'd1, 32'd1);
        run_alu("sltu", 5'b00011, 32'hFFFF_FFFE, 32'd1, 32'd0);
        run_alu("sra", 5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_alu("srl", 5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_alu("sll", 5'b00001, 32'd1, 32'h0000_003F, 32'h8000_0000);
        run_alu("xor", 5'b00100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        run_alu("or", 5'b00110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        run_alu("and", 5'b00111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        run_alu("code_11000_add", 5'b11000, 32'd5, 32'd3, 32'd8);

        // Invalid and flushed single-cycle ops produce bubbles
        instruction_valid = 1'b0;
        tick();
        chk("invalid_valid", {31'd0, result_valid}, 32'd0);
        chk("invalid_out", alu_out_address, 32'd0);
        set_op(5'b00000, 32'd1, 32'd2);
        mispredict_flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, result_valid}, 32'd0);
        mispredict_flush = 1'b0;

`ifdef EXEC_MULDIV_EN
        run_mop("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run_mop("mulh", 5'b10001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_mop("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_mop("mul", 5'b10000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run_mop("div_by0", 5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_mop("rem_by0", 5'b10110, 32'd7, 32'd0, 32'd7);
        run_mop("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mop("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_mop("divu", 5'b10101, 32'd20, 32'd3, 32'd6);
        run_mop("remu", 5'b10111, 32'd20, 32'd3, 32'd2);
        run_mop("div_neg", 5'b10100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_mop("rem_neg", 5'b10110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);

        // Flush during BUSY cycle 10 aborts the divide
        set_op(5'b10100, 32'd100, 32'd7);
        #1;
        chk("abort_stall_start", {31'd0, stall}, 32'd1);
        repeat (11) tick();
        chk("abort_stall_busy", {31'd0, stall}, 32'd1);
        mispredict_flush = 1'b1;
        #1;
        chk("abort_stall_gated", {31'd0, stall}, 32'd0);
        tick();
        chk("abort_valid", {31'd0, result_valid}, 32'd0);
        mispredict_flush = 1'b0;
        set_op(5'b00000, 32'd5, 32'd3);
        #1;
        chk("abort_idle_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("abort_next_add", alu_out_address, 32'd8);
        chk("abort_next_valid", {31'd0, result_valid}, 32'd1);
`else
        set_op(5'b10000, 32'd5, 32'd3);
        #1;
        chk("nomd_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("nomd_result", alu_out_address, 32'd8);
        chk("nomd_valid", {31'd0, result_valid}, 32'd1);
`endif

        // Reset in the middle of a DIV, then a plain ADD
        pc_address = 32'h0000_2000; imm = 32'h0000_0004;
        set_op(5'b10100, 32'd7, 32'd3);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("midrst_out", alu_out_address, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_target", branch_target, 32'd0);
        chk("midrst_taken", {31'd0, branch_taken}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        set_op(5'b00000, 32'd5, 32'd3);
        rst = 1'b1;
        #1;
        chk("postrst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("postrst_add", alu_out_address, 32'h0000_0008);
        chk("postrst_valid", {31'd0, result_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the RISC-V pipeline, sitting between decode/issue and memory. It provides:
- three-source operand forwarding;
- a single-cycle integer ALU with registered outputs;
- real conditional-branch resolution, with the target taken from a dedicated immediate;
- an optional iterative multiply/divide unit that stalls upstream while busy.

Mispredict flush cancels work in flight.

## Interface
- XLEN, 32: datapath width (≥8, power of two).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mispredict_flush  in  1  cancel current/in-flight instruction.
- instruction_valid  in  1  instruction presented this cycle.
- alu_control  in  5  operation code.
- opa_mux_in, opb_mux_in  in  XLEN  decoded operands A/B.
- pc_address  in  XLEN  instruction PC.
- imm  in  XLEN  branch offset.
- is_branch  in  1  conditional branch.
- branch_funct3  in  3  branch condition.
- forward_a, forward_b  in  2  source select:
  - 00 = mux_in
  - 01 = ex_data
  - 10 = mem_data
  - 11 = wb_data
- ex_data, mem_data, wb_data  in  XLEN  forwarded results.
- alu_out_address  out  XLEN  registered result.
- result_valid  out  1  registered result valid.
- branch_target  out  XLEN  registered pc_address + imm.
- branch_taken  out  1  registered condition outcome.
- stall  out  1  combinational; upstream must hold inputs.

## Operation
- **Operand selection:** A and B are selected by forward_a/forward_b with no precedence (explicit select). All arithmetic and comparisons use the selected values.
- **ALU codes** (anything unlisted executes ADD):
  - 00000 ADD, 01000 SUB
  - 00001 SLL, 00101 SRL, 01101 SRA (shift amount = B[log2(XLEN)-1:0])
  - 00010 SLT (signed), 00011 SLTU
  - 00100 XOR, 00110 OR, 00111 AND
- **M codes:** 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. 11xxx executes ADD.
- **Branch conditions** (branch_funct3): 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Codes 010/011 are never taken.
  - branch_taken = is_branch & condition.
  - branch_target = pc_address + imm, mod 2^XLEN, regardless of is_branch.
- **Output register update**, each edge, in priority order:
  - Flush, or !instruction_valid: all outputs cleared to 0.
  - stall high: all outputs cleared to 0 (bubble).
  - Single-cycle op: outputs are loaded and result_valid is set to 1.
- **MUL/DIV state machine:**
  - IDLE: a valid M op with no flush asserts stall combinationally. At the edge, operands are latched, count is zeroed, and the FSM moves to BUSY.
  - BUSY: one shift-add (MUL) or restoring-divide (DIV) step per cycle, on magnitudes. Stall stays high. After XLEN steps the FSM moves to DONE.
  - DONE: stall is low. Signs are fixed up and the result is written to alu_out_address with result_valid = 1. The FSM returns to IDLE. The held instruction is consumed and is not restarted.
- **MUL/DIV result rules:**
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half of the 2·XLEN product.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN; remainder = 0.
  - Latency is fixed; there is no early-out.
- **Flush:** mispredict_flush in any state forces the FSM to IDLE and clears outputs at the edge. stall is gated low in the same cycle.
- **Reset:** rst low clears all outputs to 0, forces the FSM to IDLE and clears count immediately. stall reads 0 while reset is held.

## Timing
- Single-cycle ops: inputs sampled at edge N; outputs valid after edge N.
- M op first presented before edge 0:
  - stall is high for exactly XLEN+1 cycles (before edges 0..XLEN).
  - The result is registered at edge XLEN+1. For XLEN=32, stall is high for 33 cycles and the result appears at edge 33.
- Upstream must hold all inputs constant while stall is high.
- A back-to-back M op can be accepted in the cycle after DONE.
- Flush received during BUSY: stall drops in that cycle, and result_valid stays 0 for the aborted op.

## Configuration
- EXEC_MULDIV_EN defined: the M codes and the FSM are built as described.
- EXEC_MULDIV_EN undefined:
  - No FSM; stall is tied to 0.
  - 1xxxx codes execute ADD.
  - All ops are single-cycle.

## Test plan
- **Reset:** with XLEN=32, assert rst low in the middle of a BUSY DIV -> all outputs 0, stall 0, FSM IDLE. After release, ADD 5+3 -> alu_out_address 0x8, result_valid 1.
- **Forwarding from WB:** forward_a=11, wb_data=7, opb_mux_in=3, ADD, pc=0x1000, imm=0x10 -> result 0xA, branch_target 0x1010, branch_taken 0.
- **Signed vs unsigned branch:** A=0xFFFFFFFE, B=1, pc=0x1000, imm=0x40.
  - BLT -> taken 1, target 0x1040.
  - BLTU -> taken 0.
  - Same operands with SLT -> 1; with SLTU -> 0.
- **Multiply** (EXEC_MULDIV_EN), A=0xFFFFFFFF, B=2:
  - MULHU -> 0x00000001; MULH -> 0xFFFFFFFF; MUL -> 0xFFFFFFFE.
  - For each: stall high for exactly 33 cycles, result_valid pulses once at edge 33.
- **Divide corner cases:**
  - DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - DIVU 20/3 -> 6; REMU -> 2.
- **Flush abort and macro-off build:**
  - mispredict_flush on BUSY cycle 10 -> stall low that cycle, no result_valid. A following ADD completes in one cycle.
  - With the macro undefined, code 10000 on 5,3 -> result 0x8 in one cycle, stall never high.
